// File: rtl/seq_multiplier_16bits_if.sv
// Handshake/result bundle between the datapath controller and the sequential
// multiplier.
//   start, a, b          : request pulse and operands (controller -> multiplier)
//   signed_op            : two's-complement request, only with SEQ_MUL_SIGNED_EN
//   busy, done, hi, lo   : status pulse and split product (multiplier -> controller)
// Modports: master = controller side, slave = multiplier side.
interface seq_multiplier_16bits_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SEQ_MUL_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
`ifdef SEQ_MUL_SIGNED_EN
    output signed_op,
`endif
    output start, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
`ifdef SEQ_MUL_SIGNED_EN
    input  signed_op,
`endif
    input  start, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_multiplier_16bits.sv
// Multi-cycle shift-and-add multiplier for the MULT/MULTU path. One 16-bit
// carry-lookahead adder is reused once per iteration; the 2*WIDTH-bit product
// is delivered as hi/lo with a one-cycle done pulse.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : seq_multiplier_16bits_if.slave (start/a/b in, busy/done/hi/lo out)
// Optional: define SEQ_MUL_SIGNED_EN to add bus.signed_op (two's-complement
// operands via magnitude iteration and final negation, same latency).
// WIDTH is fixed at 16 by the adder; other values are not supported.

// 16-bit two-level carry-lookahead adder (4 groups of 4 bits).
module cla_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [3:0]  cg;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                 | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    assign gp[k] = &p[4*k +: 4];
  end

  // Group carries, fully expanded from cin.
  assign cg[0] = cin;
  assign cg[1] = gg[0] | (gp[0] & cin);
  assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  // Bit carries inside each group depend only on the group carry-in.
  for (genvar k = 0; k < 4; k++) begin : g_bit
    assign c[4*k]   = cg[k];
    assign c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
    assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
    assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                    | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
  end

  assign sum = p ^ c;
endmodule

module seq_multiplier_16bits #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_multiplier_16bits_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef SEQ_MUL_SIGNED_EN
  logic             neg;
`endif

  logic [WIDTH-1:0] addend_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic [WIDTH-1:0] acc_next_c;
  logic [WIDTH-1:0] mplier_next_c;
  logic [PW-1:0]    result_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic             neg_c;

  cla_adder_16 u_add (
    .a    (acc),
    .b    (addend_c),
    .cin  (1'b0),
    .sum  (sum_c),
    .cout (cout_c)
  );

  // One iteration: conditional add, then 33-bit right shift of {cout, sum, mplier}.
  always_comb begin
    addend_c      = mplier[0] ? mcand : '0;
    acc_next_c    = {cout_c, sum_c[WIDTH-1:1]};
    mplier_next_c = {sum_c[0], mplier[WIDTH-1:1]};
    result_c      = {acc_next_c, mplier_next_c};
`ifdef SEQ_MUL_SIGNED_EN
    if (neg) result_c = -result_c;
`endif
  end

  // Operand magnitudes at capture; -32768 maps to the unsigned 0x8000.
  always_comb begin
    mag_a_c = bus.a;
    mag_b_c = bus.b;
    neg_c   = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    if (bus.signed_op) begin
      if (bus.a[WIDTH-1]) mag_a_c = -bus.a;
      if (bus.b[WIDTH-1]) mag_b_c = -bus.b;
      neg_c = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= mag_a_c;
            mplier <= mag_b_c;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SEQ_MUL_SIGNED_EN
            neg    <= neg_c;
`endif
          end
        end
        RUN: begin
          acc    <= acc_next_c;
          mplier <= mplier_next_c;
          count  <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) begin
            hi    <= result_c[PW-1:WIDTH];
            lo    <= result_c[WIDTH-1:0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SEQ_MUL_SIGNED_EN
  // Unsigned build: the sign path is structurally absent.
  logic unused_neg;
  assign unused_neg = neg_c;
`endif

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
endmodule

// File: tb/tb_seq_multiplier_16bits.sv
// Directed, table-driven bench for seq_multiplier_16bits plus hand-written
// sequences for ignored re-start and reset during an operation.
module tb_seq_multiplier_16bits;
  logic clk;
  logic reset;

  seq_multiplier_16bits_if bus ();

  seq_multiplier_16bits dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sop;
    logic [15:0] hi;
    logic [15:0] lo;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] prev_hi = 16'h0;
  logic [15:0] prev_lo = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic sop);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
    bus.signed_op = sop;
`else
    if (sop) $display("note: signed vector skipped in unsigned build");
`endif
  endtask

  // inject=1 re-pulses start with 7*7 during RUN cycle 5.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sop,
                        input logic [15:0] ehi, input logic [15:0] elo, input bit inject);
    int  lat;
    bit  seen;
    @(negedge clk);
    drive_req(a, b, sop);
    @(posedge clk);
    #1;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 8) begin
        chk("hold_hi", 32'(bus.hi), 32'(prev_hi));
        chk("hold_lo", 32'(bus.lo), 32'(prev_lo));
        chk("busy_mid", 32'(bus.busy), 32'd1);
      end
      if (bus.done) seen = 1'b1;
      if (inject && lat == 4) begin
        @(negedge clk);
        drive_req(16'd7, 16'd7, 1'b0);
      end
      if (inject && lat == 5) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    chk("done_latency", 32'(lat), 32'd16);
    chk("hi", 32'(bus.hi), 32'(ehi));
    chk("lo", 32'(bus.lo), 32'(elo));
    prev_hi = ehi;
    prev_lo = elo;
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001});
    vecs.push_back('{16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{16'h8000, 16'h0002, 1'b0, 16'h0001, 16'h0000});
    vecs.push_back('{16'h1234, 16'h5678, 1'b0, 16'h0626, 16'h0060});
    vecs.push_back('{16'h00FF, 16'h0100, 1'b0, 16'h0000, 16'hFF00});
`ifdef SEQ_MUL_SIGNED_EN
    vecs.push_back('{16'hFFFE, 16'h0003, 1'b1, 16'hFFFF, 16'hFFFA});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0001});
    vecs.push_back('{16'hFFFE, 16'h0003, 1'b0, 16'h0002, 16'hFFFA});
    bus.signed_op = 1'b0;
`endif

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_hi", 32'(bus.hi), 32'd0);
    chk("reset_lo", 32'(bus.lo), 32'd0);
    reset = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sop, vecs[i].hi, vecs[i].lo, 1'b0);

    // Start re-pulsed mid-RUN is neither honoured nor queued.
    run_op(16'd2, 16'd2, 1'b0, 16'h0000, 16'h0004, 1'b1);
    watch_no_done("no_queued_start", 25);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Reset during RUN cycle 8 abandons the operation.
    @(negedge clk);
    drive_req(16'h00FF, 16'h0100, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_reset", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", 32'(bus.busy), 32'd0);
    chk("midrun_reset_hi", 32'(bus.hi), 32'd0);
    chk("midrun_reset_lo", 32'(bus.lo), 32'd0);
    chk("midrun_reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_hi = 16'h0;
    prev_lo = 16'h0;
    watch_no_done("no_done_after_reset", 25);
    run_op(16'd3, 16'd5, 1'b0, 16'h0000, 16'h000F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
